// File: rtl/audio_pkg.sv
// Shared types and constants for the audio ADC conditioner.
// Holds FSM encoding, sample width and the mid-scale offset.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEED,
    RUN
  } state_t;

  localparam int SW = 16;
  localparam logic [SW-1:0] MID = 16'h8000;

  typedef logic signed [SW-1:0] sample_t;

  // Unsigned 12-bit average to 16-bit two's complement around mid-scale.
  function automatic sample_t to_signed(input logic [11:0] avg);
    logic [SW-1:0] u;
    u = {avg, 4'b0} - MID;
    return sample_t'(u);
  endfunction

endpackage

// File: rtl/dc_blocker.sv
// DC tracker with saturating subtract.
// dc is a 16.DC_SHIFT fixed-point estimate of the input offset.
module dc_blocker
  import audio_pkg::*;
#(
  parameter int DC_SHIFT = 10
) (
  input  logic    clk,
  input  logic    reset,
  input  sample_t s,
  input  logic    load,
  input  logic    step,
  output sample_t y,
  output logic    clip
);

  localparam int DW = SW + DC_SHIFT;

  logic [DW-1:0] dc;
  logic [SW-1:0] dc_int;
  logic [SW:0]   diff;

  assign dc_int = dc[DW-1 -: SW];
  assign diff   = {s[SW-1], s} - {dc_int[SW-1], dc_int};

  always_comb begin
    clip = diff[SW] != diff[SW-1];
    y    = sample_t'(diff[SW-1:0]);
    if (clip) begin
      y = diff[SW] ? sample_t'(16'h8000)
                   : sample_t'(16'h7fff);
    end
  end

  // Adding y at the fractional LSB moves dc_int by y >> DC_SHIFT.
  always_ff @(posedge clk) begin
    if (reset) begin
      dc <= '0;
    end else if (load) begin
      dc <= {s, {DC_SHIFT{1'b0}}};
    end else if (step) begin
      dc <= dc + {{DC_SHIFT{y[SW-1]}}, y};
    end
  end

endmodule

// File: rtl/audio_adc_conditioner.sv
// ADC front end: block-average decimator, offset to signed,
// then DC removal. Two-stage pipeline after each block.
module audio_adc_conditioner
  import audio_pkg::*;
#(
  parameter int DECIM_LOG2 = 3,
  parameter int DC_SHIFT   = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [11:0] adc_data,
  output logic        out_valid,
  output logic [15:0] out_sample,
  output logic        clip
);

  localparam int AW = 12 + DECIM_LOG2;
  localparam int CW = (DECIM_LOG2 == 0) ? 1 : DECIM_LOG2;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((1 << DECIM_LOG2) - 1);

  state_t state, state_nx;

  logic [AW-1:0] acc, sum;
  logic [CW-1:0] cnt;
  logic [11:0]   avg;
  logic          active, take, done;

  sample_t s1;
  logic    s1_valid, s1_seed;
  logic    fire, load, step;
  sample_t y;
  logic    y_clip;

  assign active = enable && (state != IDLE);
  assign take   = active && sample_valid;
  assign done   = take && (cnt == CNT_LAST);
  assign sum    = acc + AW'(adc_data);
  assign avg    = sum[DECIM_LOG2 +: 12];

  assign fire = s1_valid && enable;
  assign load = fire && s1_seed;
  assign step = fire && !s1_seed;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (enable) state_nx = SEED;
      SEED:    if (done) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = IDLE;
    endcase
    if (!enable) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      s1         <= '0;
      s1_valid   <= 1'b0;
      s1_seed    <= 1'b0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      clip       <= 1'b0;
    end else begin
      state <= state_nx;
      if (!active) begin
        acc <= '0;
        cnt <= '0;
      end else if (take) begin
        if (done) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
      s1_valid <= done;
      if (done) begin
        s1      <= to_signed(avg);
        s1_seed <= (state == SEED);
      end
      out_valid <= fire;
      clip      <= step && y_clip;
      if (fire) begin
        out_sample <= s1_seed ? '0 : y;
      end
    end
  end

  dc_blocker #(
    .DC_SHIFT(DC_SHIFT)
  ) u_dc (
    .clk  (clk),
    .reset(reset),
    .s    (s1),
    .load (load),
    .step (step),
    .y    (y),
    .clip (y_clip)
  );

endmodule

// File: tb/tb_audio_adc_conditioner.sv
// Directed bench for audio_adc_conditioner
// (DECIM_LOG2=3, DC_SHIFT=10).
module tb_audio_adc_conditioner;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        sample_valid;
  logic [11:0] adc_data;
  logic        out_valid;
  logic [15:0] out_sample;
  logic        clip;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e_last;

  logic [15:0] q_s[$];
  logic        q_c[$];
  int          q_t[$];

  audio_adc_conditioner #(
    .DECIM_LOG2(3),
    .DC_SHIFT  (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .sample_valid(sample_valid),
    .adc_data    (adc_data),
    .out_valid   (out_valid),
    .out_sample  (out_sample),
    .clip        (clip)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      q_s.push_back(out_sample);
      q_c.push_back(clip);
      q_t.push_back(cyc);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    sample_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [11:0] d);
    sample_valid = 1'b1;
    adc_data     = d;
    @(posedge clk);
    #1;
    e_last       = cyc;
    sample_valid = 1'b0;
  endtask

  task automatic strobes(input int n, input logic [11:0] d);
    for (int i = 0; i < n; i++) strobe(d);
  endtask

  task automatic clr();
    q_s.delete();
    q_c.delete();
    q_t.delete();
  endtask

  task automatic restart();
    enable = 1'b0;
    idle(2);
    enable = 1'b1;
    idle(1);
    clr();
  endtask

  int e8;

  initial begin
    reset        = 1'b1;
    enable       = 1'b1;
    sample_valid = 1'b1;
    adc_data     = 12'h800;
    #1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_sample", 32'(out_sample), 32'd0);
      chk("rst_clip", 32'(clip), 32'd0);
    end
    reset = 1'b0;
    sample_valid = 1'b0;

    restart();
    strobes(8, 12'h800);
    e8 = e_last;
    strobes(16, 12'h800);
    idle(4);
    chk("mid_count", 32'(q_s.size()), 32'd3);
    if (q_s.size() == 3) begin
      chk("mid_lat", 32'(q_t[0]), 32'(e8 + 1));
      for (int k = 0; k < 3; k++) begin
        chk("mid_sample", 32'(q_s[k]), 32'd0);
        chk("mid_clip", 32'(q_c[k]), 32'd0);
      end
    end

    restart();
    strobes(8, 12'h800);
    strobes(16, 12'hfff);
    idle(4);
    chk("step_count", 32'(q_s.size()), 32'd3);
    if (q_s.size() == 3) begin
      chk("step_seed", 32'(q_s[0]), 32'd0);
      chk("step_y1", 32'(q_s[1]), 32'd32752);
      chk("step_c1", 32'(q_c[1]), 32'd0);
      chk("step_y2", 32'(q_s[2]), 32'd32721);
    end

    restart();
    strobes(8, 12'h000);
    strobes(8, 12'hfff);
    idle(4);
    chk("sat_count", 32'(q_s.size()), 32'd2);
    if (q_s.size() == 2) begin
      chk("sat_c0", 32'(q_c[0]), 32'd0);
      chk("sat_y", 32'(q_s[1]), 32'd32767);
      chk("sat_clip", 32'(q_c[1]), 32'd1);
    end

    restart();
    strobes(8, 12'h800);
    for (int i = 0; i < 64; i++) strobe(12'(i % 8));
    idle(4);
    chk("b2b_count", 32'(q_s.size()), 32'd9);
    if (q_s.size() == 9) begin
      for (int k = 1; k < 9; k++)
        chk("b2b_gap", 32'(q_t[k] - q_t[k-1]), 32'd8);
      chk("b2b_y1", 32'(q_s[1]), 32'h8030);
      chk("b2b_y2", 32'(q_s[2]), 32'h8050);
      chk("b2b_y3", 32'(q_s[3]), 32'h8070);
      chk("b2b_clip", 32'(q_c[3]), 32'd0);
    end

    restart();
    strobes(5, 12'h000);
    enable = 1'b0;
    idle(1);
    enable = 1'b1;
    idle(1);
    strobes(8, 12'h800);
    e8 = e_last;
    strobes(8, 12'h800);
    idle(4);
    chk("abort_count", 32'(q_s.size()), 32'd2);
    if (q_s.size() == 2) begin
      chk("abort_lat", 32'(q_t[0]), 32'(e8 + 1));
      chk("abort_seed", 32'(q_s[0]), 32'd0);
      chk("abort_run", 32'(q_s[1]), 32'd0);
    end

    restart();
    strobes(8, 12'h800);
    enable = 1'b0;
    idle(4);
    chk("pipe_drop", 32'(q_s.size()), 32'd0);

    restart();
    strobes(8, 12'h800);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(4);
    chk("rst_pipe", 32'(q_s.size()), 32'd0);
    chk("rst_out", 32'(out_sample), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_adc_conditioner.md
AUDIO_ADC_CONDITIONER -- requirements
Module: audio_adc_conditioner

Interface
REQ-001 Parameter DECIM_LOG2, default 3, log2 of the number of ADC samples averaged per output sample (range 0..6).
REQ-002 Parameter DC_SHIFT, default 10, right-shift that sets the DC-tracker time constant (range 4..15).
REQ-003 clk  input  1  single clock; the ADC-side 135 MHz domain.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 enable  input  1  conditioner run enable, driven from the master reset_n.
REQ-006 sample_valid  input  1  one-cycle strobe from the SPI ADC core when adc_data is valid.
REQ-007 adc_data  input  12  unsigned ADC code; 0x800 is mid-scale.
REQ-008 out_valid  output  1  one-cycle strobe when out_sample updates.
REQ-009 out_sample  output  16  signed, DC-removed, decimated audio sample for the LPF/HDMI audio path.
REQ-010 clip  output  1  one-cycle strobe, coincident with out_valid, when out_sample saturated.

Function
REQ-011 The FSM SHALL have three states: IDLE, SEED and RUN.
REQ-012 IDLE->SEED SHALL occur on enable=1.
REQ-013 SEED->RUN SHALL occur after the first completed block.
REQ-014 Any state SHALL go to IDLE when enable=0, within the same cycle.
REQ-015 In IDLE the block SHALL hold the accumulator and block counter at 0 and ignore sample_valid.
REQ-016 In SEED or RUN, each sample_valid SHALL add adc_data to an accumulator of width 12+DECIM_LOG2 and increment a DECIM_LOG2-bit counter.
REQ-017 A block SHALL complete on the sample_valid at which the counter equals 2^DECIM_LOG2-1; the counter then wraps to 0 and the accumulator restarts with no lost sample.
REQ-018 Block average SHALL be avg = (acc + adc_data) >> DECIM_LOG2, truncating.
REQ-019 The signed sample SHALL be s = {avg,4'b0} - 0x8000, as 16-bit two's complement (MSB inverted).
REQ-020 The DC estimate dc SHALL be held as a signed 16.DC_SHIFT fixed-point register.
REQ-021 On the SEED block completion, dc SHALL be loaded with s, and out_sample SHALL be 0.
REQ-022 On each RUN block completion, y = s - dc_int SHALL be computed at 17 bits, saturated to [-32768, 32767], and then dc += y (full-precision arithmetic add at the fractional LSB, i.e. dc_int moves by y>>DC_SHIFT).
REQ-023 clip SHALL assert when saturation occurs.
REQ-024 Latency: out_valid SHALL pulse exactly 2 clk cycles after the completing sample_valid (stage 1: average/offset; stage 2: subtract/saturate/register).
REQ-025 out_sample SHALL hold its value between out_valid pulses.
REQ-026 sample_valid on consecutive cycles SHALL be supported; throughput SHALL be 1 sample/cycle.
REQ-027 sample_valid arriving while the pipeline is busy SHALL be accepted.
REQ-028 If enable falls mid-block, the partial block SHALL be discarded with no out_valid.
REQ-029 If enable falls with a block in the pipeline, that pending out_valid SHALL be suppressed.
REQ-030 Re-enable SHALL restart in SEED.
REQ-031 With DECIM_LOG2=0, every sample SHALL complete a block.

Reset
REQ-032 On reset=1: state=IDLE; accumulator, counter, pipeline valids and dc SHALL be 0; out_valid=0; out_sample=0x0000; clip=0.
REQ-033 Reset SHALL take priority over enable and sample_valid in the same cycle.
REQ-034 Reset mid-block or mid-pipeline SHALL abort with no out_valid.

Structure
REQ-035 State encoding (IDLE/SEED/RUN), the mid-scale constant 0x8000 and the 16-bit audio sample width SHALL live in shared package audio_pkg.
REQ-036 DC tracking and saturation SHALL be one sub-module, dc_blocker (inputs: s, load, step; outputs: y, clip).
REQ-037 The FSM, decimator and pipeline SHALL remain in the top.

Verification (DECIM_LOG2=3, DC_SHIFT=10)
REQ-038 Reset check: reset held 3 cycles with enable=1 and sample_valid=1 -> out_valid=0, out_sample=0x0000, clip=0 throughout.
REQ-039 Constant mid-scale: enable, then 24 strobes of 0x800 -> three out_valid pulses, all out_sample=0x0000, the first (SEED) at strobe 8 + 2 cycles.
REQ-040 Step response: seed with 8x 0x800, then 8x 0xFFF -> out_sample=32752 (0x7FF0); next block of 0xFFF -> 32752 - (32752>>10) = 32721.
REQ-041 Saturation: seed with 8x 0x000 (dc=-32768), then 8x 0xFFF -> out_sample=32767 and clip=1 coincident with out_valid.
REQ-042 Back-to-back: sample_valid every cycle for 64 cycles -> out_valid every 8 cycles; averaging correct with a ramp input (block 0..7 -> avg 3).
REQ-043 Abort: after 5 strobes drop enable 1 cycle, re-enable, then 8 strobes -> no out_valid until the 8th post-re-enable strobe + 2 cycles, treated as SEED (out_sample=0).
